// File: rtl/pilot_extract.sv
// Receive-side pilot extractor: tracks frame/pilot position, strips pilots onto an
// unthrottled port and forwards data samples through a 2-entry valid/ready FIFO.
module pilot_extract #(
  parameter int DATA_W    = 32,
  parameter int CNT_W     = 13,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CNT_W-1:0]     frame_length,
  input  logic [CNT_W-1:0]     pilot_interval,
  input  logic [DATA_W-1:0]    pilot_value,
  input  logic [DATA_W-1:0]    signal_in,
  input  logic                 valid_in,
  input  logic                 sof_in,
  output logic                 ready_out,
  output logic [DATA_W-1:0]    signal_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 data_last,
  output logic [DATA_W-1:0]    pilot_out,
  output logic                 pilot_valid,
  output logic                 pilot_match,
  output logic                 frame_end,
  output logic                 error,
  output logic                 cfg_err,
  output logic [ERR_CNT_W-1:0] mismatch_cnt
);

  logic [CNT_W-1:0] r_cnt_frame, r_cnt_pilot;
  logic [CNT_W-1:0] w_eff_frame, w_eff_pilot;
  logic [CNT_W-1:0] w_nxt_frame, w_nxt_pilot;
  logic             w_accept, w_is_pilot, w_is_last, w_push, w_pop;
  logic             r_init;
  logic [DATA_W:0]  r_mem [2];
  logic             r_wptr, r_rptr;
  logic [1:0]       r_count;

  assign cfg_err   = (pilot_interval < CNT_W'(2)) | (frame_length == '0)
                   | (pilot_interval > frame_length);
  // r_init holds ready low until the first edge after reset release
  assign ready_out = r_init & ~cfg_err & (r_count != 2'd2);
  assign w_accept  = valid_in & ready_out;

  always_comb begin
    w_eff_frame = sof_in ? '0 : r_cnt_frame;
    w_eff_pilot = sof_in ? '0 : r_cnt_pilot;
    w_is_pilot  = (w_eff_pilot == '0);
    w_is_last   = (w_eff_frame == frame_length - CNT_W'(1));
    w_nxt_frame = w_eff_frame + CNT_W'(1);
    w_nxt_pilot = (w_eff_pilot == pilot_interval - CNT_W'(1)) ? '0 : w_eff_pilot + CNT_W'(1);
    if (w_is_last) begin
      w_nxt_frame = '0;
      w_nxt_pilot = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_init      <= 1'b0;
      r_cnt_frame <= '0;
      r_cnt_pilot <= '0;
      error       <= 1'b0;
      frame_end   <= 1'b0;
    end else begin
      r_init    <= 1'b1;
      error     <= w_accept & sof_in & (r_cnt_frame != '0);
      frame_end <= w_accept & w_is_last;
      if (w_accept) begin
        r_cnt_frame <= w_nxt_frame;
        r_cnt_pilot <= w_nxt_pilot;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pilot_out    <= '0;
      pilot_valid  <= 1'b0;
      pilot_match  <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      pilot_valid <= w_accept & w_is_pilot;
      pilot_match <= w_accept & w_is_pilot & (signal_in == pilot_value);
      if (w_accept & w_is_pilot) begin
        pilot_out <= signal_in;
        if ((signal_in != pilot_value) && (mismatch_cnt != '1))
          mismatch_cnt <= mismatch_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign w_push     = w_accept & ~w_is_pilot;
  assign w_pop      = valid_out & ready_in;
  assign valid_out  = (r_count != 2'd0);
  assign signal_out = r_mem[r_rptr][DATA_W-1:0];
  assign data_last  = valid_out & r_mem[r_rptr][DATA_W];

  // Push never meets a full FIFO because ready_out already excludes count==2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {w_is_last, signal_in};
        r_wptr        <= ~r_wptr;
      end
      if (w_pop)
        r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_pilot_extract.sv
// Directed bench for pilot_extract: config table plus hand-built frame sequences
// checked against expected pilot/data/frame_end queues.
module tb_pilot_extract;
  localparam int DW = 32;
  localparam int CW = 13;
  localparam int EW = 4;
  localparam logic [31:0] PV = 32'h7FFF0000;

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] frame_length, pilot_interval;
  logic [DW-1:0] pilot_value, signal_in, signal_out, pilot_out;
  logic          valid_in, sof_in, ready_out, valid_out, ready_in, data_last;
  logic          pilot_valid, pilot_match, frame_end, error, cfg_err;
  logic [EW-1:0] mismatch_cnt;

  pilot_extract #(.DATA_W(DW), .CNT_W(CW), .ERR_CNT_W(EW)) dut (
    .clk(clk), .rst(rst), .frame_length(frame_length), .pilot_interval(pilot_interval),
    .pilot_value(pilot_value), .signal_in(signal_in), .valid_in(valid_in), .sof_in(sof_in),
    .ready_out(ready_out), .signal_out(signal_out), .valid_out(valid_out), .ready_in(ready_in),
    .data_last(data_last), .pilot_out(pilot_out), .pilot_valid(pilot_valid),
    .pilot_match(pilot_match), .frame_end(frame_end), .error(error), .cfg_err(cfg_err),
    .mismatch_cnt(mismatch_cnt));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, stalls = 0, err_seen = 0;
  logic [32:0] exp_p[$], got_p[$], exp_d[$], got_d[$];
  logic [1:0]  exp_fe[$], got_fe[$];

  always @(negedge clk) begin
    if (pilot_valid) got_p.push_back({pilot_match, pilot_out});
    if (valid_out && ready_in) got_d.push_back({data_last, signal_out});
    if (frame_end) got_fe.push_back({pilot_valid, valid_out & data_last});
    if (error) err_seen++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic s);
    int k = 0;
    signal_in = d; sof_in = s; valid_in = 1'b1;
    while (!ready_out && k < 50) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 50) chk("send timeout", 1, 0);
    stalls += k;
    @(posedge clk); #1;
    valid_in = 1'b0; sof_in = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag);
    chk($sformatf("%s pilot count", tag), got_p.size(), exp_p.size());
    for (int i = 0; i < exp_p.size() && i < got_p.size(); i++)
      chk($sformatf("%s pilot[%0d]", tag, i), got_p[i], exp_p[i]);
    chk($sformatf("%s data count", tag), got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++)
      chk($sformatf("%s data[%0d]", tag, i), got_d[i], exp_d[i]);
    chk($sformatf("%s frame_end count", tag), got_fe.size(), exp_fe.size());
    for (int i = 0; i < exp_fe.size() && i < got_fe.size(); i++)
      chk($sformatf("%s frame_end align[%0d]", tag, i), got_fe[i], exp_fe[i]);
    exp_p.delete(); got_p.delete(); exp_d.delete(); got_d.delete();
    exp_fe.delete(); got_fe.delete();
  endtask

  typedef struct {
    logic [CW-1:0] fl;
    logic [CW-1:0] pi;
    logic          exp_err;
  } cfg_vec_t;
  cfg_vec_t cv[9];

  initial begin
    cv[0] = '{13'd8, 13'd4, 1'b0};
    cv[1] = '{13'd8, 13'd1, 1'b1};
    cv[2] = '{13'd8, 13'd0, 1'b1};
    cv[3] = '{13'd0, 13'd2, 1'b1};
    cv[4] = '{13'd8, 13'd9, 1'b1};
    cv[5] = '{13'd8, 13'd8, 1'b0};
    cv[6] = '{13'd2, 13'd2, 1'b0};
    cv[7] = '{13'd1, 13'd2, 1'b1};
    cv[8] = '{13'h1FFF, 13'd2, 1'b0};

    rst = 1'b0; frame_length = 13'd8; pilot_interval = 13'd4; pilot_value = PV;
    signal_in = '0; valid_in = 1'b0; sof_in = 1'b0; ready_in = 1'b1;
    #12;
    chk("reset ready_out", ready_out, 0);
    chk("reset valid_out", valid_out, 0);
    chk("reset pilot_valid", pilot_valid, 0);
    chk("reset mismatch_cnt", mismatch_cnt, 0);
    chk("reset cfg_err", cfg_err, 0);
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("ready before first edge", ready_out, 0);
    @(posedge clk); #1;
    chk("ready after first edge", ready_out, 1);

    for (int i = 0; i < 9; i++) begin
      frame_length = cv[i].fl; pilot_interval = cv[i].pi; #1;
      chk($sformatf("cfg_err vec%0d", i), cfg_err, cv[i].exp_err);
      chk($sformatf("ready_out vec%0d", i), ready_out, !cv[i].exp_err);
    end
    frame_length = 13'd8; pilot_interval = 13'd4; #1;

    // matching pilots
    for (int i = 0; i < 8; i++) send((i == 0 || i == 4) ? PV : 32'h10 + i, i == 0);
    drain();
    exp_p = '{{1'b1, PV}, {1'b1, PV}};
    exp_d = '{{1'b0, 32'h11}, {1'b0, 32'h12}, {1'b0, 32'h13}, {1'b0, 32'h15},
              {1'b0, 32'h16}, {1'b1, 32'h17}};
    exp_fe = '{2'b01};
    check_stream("match");
    chk("mismatch_cnt after matching", mismatch_cnt, 0);

    // basic frame, mismatched pilots
    for (int i = 0; i < 8; i++) send(i, i == 0);
    drain();
    exp_p = '{{1'b0, 32'd0}, {1'b0, 32'd4}};
    exp_d = '{{1'b0, 32'd1}, {1'b0, 32'd2}, {1'b0, 32'd3}, {1'b0, 32'd5},
              {1'b0, 32'd6}, {1'b1, 32'd7}};
    exp_fe = '{2'b01};
    check_stream("basic");
    chk("mismatch_cnt basic", mismatch_cnt, 2);
    chk("no stalls at full rate", stalls, 0);
    chk("no error basic", err_seen, 0);

    // backpressure
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h100 + i, i == 0);
    chk("ready_out low when full", ready_out, 0);
    chk("head valid while stalled", valid_out, 1);
    signal_in = 32'h103; valid_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("ready_out stays low", ready_out, 0);
    chk("head held stable", signal_out, 32'h101);
    ready_in = 1'b1;
    for (int i = 3; i < 8; i++) send(32'h100 + i, 1'b0);
    drain();
    exp_p = '{{1'b0, 32'h100}, {1'b0, 32'h104}};
    exp_d = '{{1'b0, 32'h101}, {1'b0, 32'h102}, {1'b0, 32'h103}, {1'b0, 32'h105},
              {1'b0, 32'h106}, {1'b1, 32'h107}};
    exp_fe = '{2'b01};
    check_stream("bp");
    chk("mismatch_cnt bp", mismatch_cnt, 4);

    // final position is a pilot
    frame_length = 13'd9;
    for (int i = 0; i < 9; i++) send(32'h200 + i, i == 0);
    drain();
    exp_p = '{{1'b0, 32'h200}, {1'b0, 32'h204}, {1'b0, 32'h208}};
    exp_d = '{{1'b0, 32'h201}, {1'b0, 32'h202}, {1'b0, 32'h203}, {1'b0, 32'h205},
              {1'b0, 32'h206}, {1'b0, 32'h207}};
    exp_fe = '{2'b10};
    check_stream("fl9");
    chk("mismatch_cnt fl9", mismatch_cnt, 7);

    // sof mid-frame realigns
    frame_length = 13'd8;
    for (int i = 0; i < 11; i++) send(32'h300 + i, i == 0 || i == 3);
    drain();
    exp_p = '{{1'b0, 32'h300}, {1'b0, 32'h303}, {1'b0, 32'h307}};
    exp_d = '{{1'b0, 32'h301}, {1'b0, 32'h302}, {1'b0, 32'h304}, {1'b0, 32'h305},
              {1'b0, 32'h306}, {1'b0, 32'h308}, {1'b0, 32'h309}, {1'b1, 32'h30A}};
    exp_fe = '{2'b01};
    check_stream("sof");
    chk("error pulses", err_seen, 1);
    chk("mismatch_cnt sof", mismatch_cnt, 10);

    // saturation of the mismatch counter
    frame_length = 13'd2; pilot_interval = 13'd2;
    for (int i = 0; i < 10; i++) send(32'h600 + i, 1'b0);
    drain();
    chk("mismatch_cnt reaches max", mismatch_cnt, 15);
    for (int i = 0; i < 6; i++) send(32'h700 + i, 1'b0);
    drain();
    chk("mismatch_cnt saturated", mismatch_cnt, 15);
    exp_p.delete(); got_p.delete(); exp_d.delete(); got_d.delete();
    exp_fe.delete(); got_fe.delete();

    // reset mid-frame with FIFO full
    frame_length = 13'd8; pilot_interval = 13'd4;
    ready_in = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h400 + i, i == 0);
    chk("fifo full before reset", ready_out, 0);
    rst = 1'b0; #1;
    chk("rst ready_out", ready_out, 0);
    chk("rst valid_out", valid_out, 0);
    chk("rst signal_out", signal_out, 0);
    chk("rst data_last", data_last, 0);
    chk("rst pilot_out", pilot_out, 0);
    chk("rst pilot_valid", pilot_valid, 0);
    chk("rst mismatch_cnt", mismatch_cnt, 0);
    @(posedge clk); #1;
    exp_p.delete(); got_p.delete(); exp_d.delete(); got_d.delete();
    exp_fe.delete(); got_fe.delete();
    rst = 1'b1; ready_in = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(32'h500 + i, 1'b0);
    drain();
    exp_p = '{{1'b0, 32'h500}, {1'b0, 32'h504}};
    exp_d = '{{1'b0, 32'h501}, {1'b0, 32'h502}, {1'b0, 32'h503}, {1'b0, 32'h505},
              {1'b0, 32'h506}, {1'b1, 32'h507}};
    exp_fe = '{2'b01};
    check_stream("post-reset");
    chk("mismatch_cnt post-reset", mismatch_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
